// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit with valid/ready on both sides; stage 1 computes, later stages only register.
// Optional saturation enabled by defining ADDER_PIPE_SAT_EN (adds the sat_en input).
module adder_pipe #(
  parameter int W      = 8,
  parameter int STAGES = 2,
  parameter int SIGNED = 0,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_op,
  input  logic [TAG_W-1:0] in_tag,
`ifdef ADDER_PIPE_SAT_EN
  input  logic             sat_en,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:0]       out_data,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  logic [W:0]       a_x;
  logic [W:0]       b_x;
  logic [W:0]       res;
  logic [W:0]       res_final;
  logic             ovf;

  logic [STAGES:1]  v;
  logic [STAGES:1]  rdy;
  logic             rdy_acc;
  logic [STAGES:1]  ovf_q;
  logic [W:0]       data_q [1:STAGES];
  logic [TAG_W-1:0] tag_q  [1:STAGES];

  always_comb begin
    a_x = (SIGNED != 0) ? {in_a[W-1], in_a} : {1'b0, in_a};
    b_x = (SIGNED != 0) ? {in_b[W-1], in_b} : {1'b0, in_b};
    res = in_op ? (a_x - b_x) : (a_x + b_x);
    if (SIGNED != 0)
      ovf = res[W] ^ res[W-1];
    else
      ovf = in_op ? (in_a < in_b) : res[W];
    res_final = res;
`ifdef ADDER_PIPE_SAT_EN
    // The W+1-bit result is exact, so its top bit gives the true sign for clamping.
    if (sat_en && ovf) begin
      if (SIGNED != 0)
        res_final = res[W] ? {2'b11, {(W-1){1'b0}}} : {2'b00, {(W-1){1'b1}}};
      else
        res_final = in_op ? '0 : {1'b0, {W{1'b1}}};
    end
`endif
  end

  // Ready ripples back from the consumer: a stage accepts if it is empty or anything downstream moves.
  always_comb begin
    rdy     = '0;
    rdy_acc = out_ready;
    for (int unsigned j = 0; j < STAGES; j++) begin
      rdy_acc         = rdy_acc | ~v[STAGES-j];
      rdy[STAGES-j]   = rdy_acc;
    end
  end

  assign in_ready = rst_n & rdy[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v     <= '0;
      ovf_q <= '0;
      for (int unsigned i = 1; i <= STAGES; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      if (rdy[1]) begin
        v[1] <= in_valid;
        if (in_valid) begin
          data_q[1] <= res_final;
          ovf_q[1]  <= ovf;
          tag_q[1]  <= in_tag;
        end
      end
      for (int unsigned i = 2; i <= STAGES; i++) begin
        if (rdy[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) begin
            data_q[i] <= data_q[i-1];
            ovf_q[i]  <= ovf_q[i-1];
            tag_q[i]  <= tag_q[i-1];
          end
        end
      end
    end
  end

  assign out_valid = v[STAGES];
  assign out_data  = data_q[STAGES];
  assign out_ovf   = ovf_q[STAGES];
  assign out_tag   = tag_q[STAGES];

endmodule
